// File: rtl/lbm_stream_addr_gen.sv
// lbm_stream_addr_gen
// Raster-order address sequencer for a periodic NX x NY D2Q9 lattice. For each
// node it latches the node base, its eight streaming neighbours and the
// second-buffer address. It then steps the downstream 10:1 mux select through
// 0..9 under a valid/ready handshake.
module lbm_stream_addr_gen #(
  parameter int ADDRESS_WIDTH = 10,
  parameter int NX            = 16,
  parameter int NY            = 16
) (
  input  logic                            Clk,
  input  logic                            Reset,
  input  logic                            start,
  input  logic                            ready,
  output logic signed [ADDRESS_WIDTH-1:0] Din0,
  output logic signed [ADDRESS_WIDTH-1:0] Din1,
  output logic signed [ADDRESS_WIDTH-1:0] Din2,
  output logic signed [ADDRESS_WIDTH-1:0] Din3,
  output logic signed [ADDRESS_WIDTH-1:0] Din4,
  output logic signed [ADDRESS_WIDTH-1:0] Din5,
  output logic signed [ADDRESS_WIDTH-1:0] Din6,
  output logic signed [ADDRESS_WIDTH-1:0] Din7,
  output logic signed [ADDRESS_WIDTH-1:0] Din8,
  output logic signed [ADDRESS_WIDTH-1:0] Din9,
  output logic        [3:0]               select,
  output logic                            valid,
  output logic                            busy,
  output logic                            done
);

  localparam int AW = ADDRESS_WIDTH;
  localparam int XW = (NX > 1) ? $clog2(NX) : 1;
  localparam int YW = (NY > 1) ? $clog2(NY) : 1;

  localparam logic [AW-1:0] NX_A       = AW'(NX);
  localparam logic [AW-1:0] LAST_ROW_A = AW'((NY - 1) * NX);
  localparam logic [AW-1:0] CELLS_A    = AW'(NX * NY);
  localparam logic [XW-1:0] X_MAX      = XW'(NX - 1);
  localparam logic [YW-1:0] Y_MAX      = YW'(NY - 1);
  localparam logic [3:0]    SEL_LAST   = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_NEXT,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [AW-1:0] row_q, row_d;   // y*NX, tracked incrementally instead of multiplied
  logic [3:0]    select_q, select_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          load_din;

  logic [AW-1:0] din_q [10];
  logic [AW-1:0] din_d [10];
  logic [AW-1:0] addr_set [10];

  // Periodic neighbour coordinates and row bases of the current node
  logic [XW-1:0] xp, xm;
  logic [AW-1:0] x_a, xp_a, xm_a, row_up, row_dn;

  assign xp     = (x_q == X_MAX) ? '0 : x_q + 1'b1;
  assign xm     = (x_q == '0) ? X_MAX : x_q - 1'b1;
  assign x_a    = AW'(x_q);
  assign xp_a   = AW'(xp);
  assign xm_a   = AW'(xm);
  assign row_up = (y_q == Y_MAX) ? '0 : row_q + NX_A;
  assign row_dn = (y_q == '0) ? LAST_ROW_A : row_q - NX_A;

  assign addr_set[0] = row_q + x_a;            // node base
  assign addr_set[1] = row_q + xp_a;           // E
  assign addr_set[2] = row_up + x_a;           // N
  assign addr_set[3] = row_q + xm_a;           // W
  assign addr_set[4] = row_dn + x_a;           // S
  assign addr_set[5] = row_up + xp_a;          // NE
  assign addr_set[6] = row_up + xm_a;          // NW
  assign addr_set[7] = row_dn + xm_a;          // SW
  assign addr_set[8] = row_dn + xp_a;          // SE
  assign addr_set[9] = row_q + x_a + CELLS_A;  // same node in the second buffer

  // Address registers: reloaded only in LOAD, so they hold while a transfer stalls
  generate
    for (genvar gi = 0; gi < 10; gi++) begin : g_din
      assign din_d[gi] = load_din ? addr_set[gi] : din_q[gi];

      always_ff @(posedge Clk) begin
        if (Reset) begin
          din_q[gi] <= '0;
        end else begin
          din_q[gi] <= din_d[gi];
        end
      end
    end
  endgenerate

  // Next-state logic for the sweep FSM, its position counters and its registered outputs
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    row_d    = row_q;
    select_d = select_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    load_din = 1'b0;
    case (state_q)
      S_IDLE: begin
        valid_d = 1'b0;
        if (start) begin
          state_d = S_LOAD;
          x_d     = '0;
          y_d     = '0;
          row_d   = '0;
          busy_d  = 1'b1;
        end
      end
      S_LOAD: begin
        load_din = 1'b1;
        select_d = 4'd0;
        valid_d  = 1'b1;
        state_d  = S_ISSUE;
      end
      S_ISSUE: begin
        if (ready) begin
          if (select_q == SEL_LAST) begin
            valid_d = 1'b0;
            state_d = S_NEXT;
          end else begin
            select_d = select_q + 4'd1;
          end
        end
      end
      S_NEXT: begin
        valid_d = 1'b0;
        if ((x_q == X_MAX) && (y_q == Y_MAX)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d = S_LOAD;
          if (x_q == X_MAX) begin
            x_d   = '0;
            y_d   = y_q + 1'b1;
            row_d = row_q + NX_A;
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        // done_d defaults low here, which makes done a single-cycle pulse
        x_d     = '0;
        y_d     = '0;
        row_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // FSM state, position counters and handshake outputs
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      row_q    <= '0;
      select_q <= 4'd0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      row_q    <= row_d;
      select_q <= select_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign Din0   = $signed(din_q[0]);
  assign Din1   = $signed(din_q[1]);
  assign Din2   = $signed(din_q[2]);
  assign Din3   = $signed(din_q[3]);
  assign Din4   = $signed(din_q[4]);
  assign Din5   = $signed(din_q[5]);
  assign Din6   = $signed(din_q[6]);
  assign Din7   = $signed(din_q[7]);
  assign Din8   = $signed(din_q[8]);
  assign Din9   = $signed(din_q[9]);
  assign select = select_q;
  assign valid  = valid_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_lbm_stream_addr_gen.sv
// Testbench for lbm_stream_addr_gen: full sweeps with ready held high and with
// random ready, a start pulse mid-sweep, and a reset mid-transfer. Hand-computed
// node vectors are checked from a table, and every accepted address is checked
// against a periodic-lattice model.
module tb_lbm_stream_addr_gen;

  localparam int AW    = 10;
  localparam int NX    = 16;
  localparam int NY    = 16;
  localparam int LIMIT = 20000;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic start = 1'b0;
  logic ready = 1'b0;
  logic signed [AW-1:0] din0, din1, din2, din3, din4, din5, din6, din7, din8, din9;
  logic [3:0] select;
  logic valid, busy, done;
  logic signed [AW-1:0] d [10];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 Clk = ~Clk;

  lbm_stream_addr_gen #(.ADDRESS_WIDTH(AW), .NX(NX), .NY(NY)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .ready(ready),
    .Din0(din0), .Din1(din1), .Din2(din2), .Din3(din3), .Din4(din4),
    .Din5(din5), .Din6(din6), .Din7(din7), .Din8(din8), .Din9(din9),
    .select(select), .valid(valid), .busy(busy), .done(done)
  );

  always_comb begin
    d[0] = din0; d[1] = din1; d[2] = din2; d[3] = din3; d[4] = din4;
    d[5] = din5; d[6] = din6; d[7] = din7; d[8] = din8; d[9] = din9;
  end

  typedef struct packed {
    logic [9:0]      node;
    logic [9:0][9:0] exp;
  } vec_t;

  vec_t tbl [5];

  function automatic vec_t mk(input int n, input int e0, input int e1, input int e2,
                              input int e3, input int e4, input int e5, input int e6,
                              input int e7, input int e8, input int e9);
    vec_t v;
    v.node   = 10'(n);
    v.exp[0] = 10'(e0); v.exp[1] = 10'(e1); v.exp[2] = 10'(e2); v.exp[3] = 10'(e3);
    v.exp[4] = 10'(e4); v.exp[5] = 10'(e5); v.exp[6] = 10'(e6); v.exp[7] = 10'(e7);
    v.exp[8] = 10'(e8); v.exp[9] = 10'(e9);
    return v;
  endfunction

  // Periodic-lattice reference: address k of node n
  function automatic int model(input int n, input int k);
    int x, y, dx, dy;
    x  = n % NX;
    y  = n / NX;
    dx = 0;
    dy = 0;
    case (k)
      1: dx = 1;
      2: dy = 1;
      3: dx = -1;
      4: dy = -1;
      5: begin dx = 1;  dy = 1;  end
      6: begin dx = -1; dy = 1;  end
      7: begin dx = -1; dy = -1; end
      8: begin dx = 1;  dy = -1; end
      default: ;
    endcase
    return ((y + dy + NY) % NY) * NX + ((x + dx + NX) % NX) + ((k == 9) ? NX * NY : 0);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // One sweep. rmode 0: ready high, 1: random ready. poke_node: pulse start there.
  // abort_node: assert Reset during ISSUE of that node (select 3) and return.
  task automatic sweep(input int rmode, input int poke_node, input int abort_node);
    int  cyc, node, sel, xfers, dones, done_cyc, first_valid, hold_sel;
    int  hold_d [10];
    bit  hold_pend, rdy, same, ended;
    node = 0; sel = 0; xfers = 0; dones = 0; done_cyc = -1; first_valid = -1;
    hold_sel = 0; hold_pend = 0; ended = 0;
    for (int k = 0; k < 10; k++) hold_d[k] = 0;
    start = 1'b1;
    ready = 1'b0;
    step();
    start = 1'b0;
    cyc = 1;
    chk("busy_after_start", int'(busy), 1);
    chk("valid_after_start", int'(valid), 0);
    while (!ended && cyc < LIMIT) begin
      if (hold_pend) begin
        same = 1'b1;
        for (int k = 0; k < 10; k++) if (int'(d[k]) != hold_d[k]) same = 1'b0;
        chk("stall_select_hold", int'(select), hold_sel);
        chk("stall_din_hold", int'(same), 1);
        hold_pend = 1'b0;
      end
      if (valid && first_valid < 0) first_valid = cyc;
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        chk("done_single_pulse", int'(done), 0);
        chk("idle_valid", int'(valid), 0);
        ended = 1'b1;
      end else begin
        if (done) begin
          dones++;
          done_cyc = cyc;
          chk("busy_low_at_done", int'(busy), 0);
        end
        rdy   = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        ready = rdy;
        start = 1'b0;
        if (valid) begin
          if (node == abort_node && sel == 3) begin
            Reset = 1'b1;
            step();
            chk("abort_valid", int'(valid), 0);
            chk("abort_busy", int'(busy), 0);
            chk("abort_select", int'(select), 0);
            chk("abort_din0", int'(din0), 0);
            Reset = 1'b0;
            ready = 1'b0;
            step();
            chk("abort_idle_valid", int'(valid), 0);
            $display("[TB] reset during node %0d select 3, sweep dropped", node);
            return;
          end
          if (node == poke_node && sel == 0) start = 1'b1;
          if (rdy) begin
            chk("select_order", int'(select), sel);
            chk("din_selected", int'(d[sel]), model(node, sel));
            if (sel == 0) begin
              for (int t = 0; t < 5; t++) begin
                if (int'(tbl[t].node) == node) begin
                  for (int k = 0; k < 10; k++) chk($sformatf("node%0d_din%0d", node, k), int'(d[k]), int'(tbl[t].exp[k]));
                end
              end
            end
            if (sel == 9) begin
              for (int k = 0; k < 10; k++) chk($sformatf("din%0d_at_sel9", k), int'(d[k]), model(node, k));
            end
            sel++;
            xfers++;
            if (sel == 10) begin
              $display("[TB] node %0d: 10 transfers, din0=%0d din9=%0d, cycle %0d", node, d[0], d[9], cyc);
              sel = 0;
              node++;
            end
          end else begin
            hold_pend = 1'b1;
            hold_sel  = int'(select);
            for (int k = 0; k < 10; k++) hold_d[k] = int'(d[k]);
          end
        end
        step();
        cyc++;
      end
    end
    start = 1'b0;
    ready = 1'b0;
    if (!ended) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL sweep_timeout: got %0d cycles without completion, expected done", cyc);
    end
    chk("nodes_visited", node, NX * NY);
    chk("transfers", xfers, NX * NY * 10);
    chk("done_pulses", dones, 1);
    if (rmode == 0) begin
      chk("start_to_done_cycles", done_cyc, NX * NY * 12 + 1);
      chk("start_to_valid_cycles", first_valid, 2);
    end
  endtask

  initial begin
    tbl[0] = mk(0,   0,   1,   16,  15,  240, 17,  31,  255, 241, 256);
    tbl[1] = mk(15,  15,  0,   31,  14,  255, 16,  30,  254, 240, 271);
    tbl[2] = mk(16,  16,  17,  32,  31,  0,   33,  47,  15,  1,   272);
    tbl[3] = mk(100, 100, 101, 116, 99,  84,  117, 115, 83,  85,  356);
    tbl[4] = mk(255, 255, 240, 15,  254, 239, 0,   14,  238, 224, 511);

    Reset = 1'b1;
    step();
    step();
    chk("reset_valid", int'(valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_select", int'(select), 0);
    for (int k = 0; k < 10; k++) chk($sformatf("reset_din%0d", k), int'(d[k]), 0);
    Reset = 1'b0;
    step();
    chk("idle_valid", int'(valid), 0);

    $display("[TB] sweep 1: ready high, start pulsed at node 37");
    sweep(0, 37, -1);
    step();
    $display("[TB] sweep 2: random ready");
    sweep(1, -1, -1);
    step();
    $display("[TB] sweep 3: reset during node 100");
    sweep(0, -1, 100);
    $display("[TB] sweep 4: fresh start after reset");
    sweep(0, -1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
